// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic phase scheduler: phase encodings,
// default timing width and light-colour constants.
package traffic_pkg;

  localparam int W_DEFAULT = 8;

  typedef enum logic [1:0] {
    PH_IDLE   = 2'd0,
    PH_GREEN  = 2'd1,
    PH_YELLOW = 2'd2
  } phase_t;

  localparam logic [1:0] LIGHT_RED    = 2'd0;
  localparam logic [1:0] LIGHT_YELLOW = 2'd1;
  localparam logic [1:0] LIGHT_GREEN  = 2'd2;

  // Both enables high is treated as IDLE, not as a valid phase.
  function automatic phase_t decode_phase(input logic count_g, input logic count_y);
    phase_t p;
    p = PH_IDLE;
    if (count_g && !count_y) p = PH_GREEN;
    else if (count_y && !count_g) p = PH_YELLOW;
    return p;
  endfunction

endpackage

// File: rtl/traffic_phase_scheduler_phase_timer.sv
// Per-phase elapsed tick counter with saturation, plus the phase-entry
// snapshot of the duration configuration.
module phase_timer
  import traffic_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         phase_change,
  input  logic         counting,
  input  logic         tick,
  input  logic [W-1:0] cfg_green_min,
  input  logic [W-1:0] cfg_green_max,
  input  logic [W-1:0] cfg_yellow,
  output logic [W-1:0] elapsed,
  output logic [W-1:0] green_min_q,
  output logic [W-1:0] green_max_q,
  output logic [W-1:0] yellow_q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      elapsed     <= '0;
      green_min_q <= '0;
      green_max_q <= '0;
      yellow_q    <= '0;
    end else if (phase_change) begin
      // Snapshot durations on entry so mid-phase cfg edits are ignored.
      elapsed     <= '0;
      green_min_q <= cfg_green_min;
      green_max_q <= cfg_green_max;
      yellow_q    <= cfg_yellow;
    end else if (counting && tick && (elapsed != {W{1'b1}})) begin
      elapsed <= elapsed + 1'b1;
    end
  end

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Decides when the current green or yellow phase is complete (max-out,
// gap-out, yellow timeout) and tracks which road holds right of way.
module traffic_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tick,
  input  logic         count_g,
  input  logic         count_y,
  input  logic         req1,
  input  logic         req2,
  input  logic [W-1:0] cfg_green_min,
  input  logic [W-1:0] cfg_green_max,
  input  logic [W-1:0] cfg_yellow,
  output logic         count_done_g,
  output logic         count_done_y,
  output logic         active_road,
  output logic [W-1:0] elapsed,
  output logic         pend1,
  output logic         pend2
);

  phase_t       phase_d;
  phase_t       phase_q;
  logic         phase_change;
  logic         done_sent;
  logic [W-1:0] green_min_q;
  logic [W-1:0] green_max_q;
  logic [W-1:0] yellow_q;
  logic         road1_green;
  logic         road2_green;
  logic         own_req;
  logic         other_pend;
  logic         fire_g;
  logic         fire_y;
  logic         pend1_d;
  logic         pend2_d;

  assign phase_d      = decode_phase(count_g, count_y);
  assign phase_change = (phase_d != phase_q);
  assign road1_green  = (phase_d == PH_GREEN) && !active_road;
  assign road2_green  = (phase_d == PH_GREEN) && active_road;
  assign own_req      = active_road ? req2 : req1;
  assign other_pend   = active_road ? pend1 : pend2;

  phase_timer #(.W(W)) u_timer (
    .clk          (clk),
    .rst          (rst),
    .phase_change (phase_change),
    .counting     (phase_d != PH_IDLE),
    .tick         (tick),
    .cfg_green_min(cfg_green_min),
    .cfg_green_max(cfg_green_max),
    .cfg_yellow   (cfg_yellow),
    .elapsed      (elapsed),
    .green_min_q  (green_min_q),
    .green_max_q  (green_max_q),
    .yellow_q     (yellow_q)
  );

  always_comb begin
    fire_g  = 1'b0;
    fire_y  = 1'b0;
    pend1_d = pend1;
    pend2_d = pend2;
    // Evaluation only once the phase is stable, so elapsed and cfg are current.
    if (!phase_change && !done_sent) begin
      if (phase_d == PH_GREEN)
        fire_g = (elapsed >= green_max_q) ||
                 ((elapsed >= green_min_q) && other_pend && !own_req);
      if (phase_d == PH_YELLOW)
        fire_y = (elapsed >= yellow_q);
    end
    if (phase_change && road1_green) pend1_d = 1'b0;
    if (phase_change && road2_green) pend2_d = 1'b0;
    if ((phase_d != PH_IDLE) && req1 && !road1_green) pend1_d = 1'b1;
    if ((phase_d != PH_IDLE) && req2 && !road2_green) pend2_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q      <= PH_IDLE;
      done_sent    <= 1'b0;
      count_done_g <= 1'b0;
      count_done_y <= 1'b0;
      active_road  <= 1'b0;
      pend1        <= 1'b0;
      pend2        <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      count_done_g <= fire_g;
      count_done_y <= fire_y;
      pend1        <= pend1_d;
      pend2        <= pend2_d;
      if (fire_g || fire_y) done_sent <= 1'b1;
      else if (phase_change) done_sent <= 1'b0;
      if (fire_y) active_road <= ~active_road;
    end
  end

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Self-checking bench: directed scenarios plus random traffic, each cycle
// compared against a tick-level behavioural model of the scheduler rules.
module tb_traffic_phase_scheduler;

  localparam int W   = 8;
  localparam int SAT = (1 << W) - 1;

  logic         clk;
  logic         rst;
  logic         tick;
  logic         count_g;
  logic         count_y;
  logic         req1;
  logic         req2;
  logic [W-1:0] cfg_green_min;
  logic [W-1:0] cfg_green_max;
  logic [W-1:0] cfg_yellow;
  logic         count_done_g;
  logic         count_done_y;
  logic         active_road;
  logic [W-1:0] elapsed;
  logic         pend1;
  logic         pend2;

  traffic_phase_scheduler #(.W(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .tick         (tick),
    .count_g      (count_g),
    .count_y      (count_y),
    .req1         (req1),
    .req2         (req2),
    .cfg_green_min(cfg_green_min),
    .cfg_green_max(cfg_green_max),
    .cfg_yellow   (cfg_yellow),
    .count_done_g (count_done_g),
    .count_done_y (count_done_y),
    .active_road  (active_road),
    .elapsed      (elapsed),
    .pend1        (pend1),
    .pend2        (pend2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state: phase 0 = idle, 1 = green, 2 = yellow.
  int m_ph, m_el, m_gmin, m_gmax, m_y;
  bit m_sent, m_dg, m_dy, m_road, m_p1, m_p2;

  // Pulse statistics for the directed scenarios.
  int g_cnt, y_cnt, g_el, y_el, y_at, cyc;
  int prev_el;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    int  p;
    bit  entry, n_dg, n_dy, np1, np2, own_req, other_pend;
    if (rst) begin
      m_ph = 0; m_el = 0; m_gmin = 0; m_gmax = 0; m_y = 0;
      m_sent = 0; m_dg = 0; m_dy = 0; m_road = 0; m_p1 = 0; m_p2 = 0;
      return;
    end
    p = (count_g && !count_y) ? 1 : ((count_y && !count_g) ? 2 : 0);
    entry = (p != m_ph);
    n_dg = 0;
    n_dy = 0;
    np1 = m_p1;
    np2 = m_p2;
    if (entry && p == 1 && m_road == 0) np1 = 0;
    if (entry && p == 1 && m_road == 1) np2 = 0;
    if (p != 0 && req1 && !(p == 1 && m_road == 0)) np1 = 1;
    if (p != 0 && req2 && !(p == 1 && m_road == 1)) np2 = 1;
    if (entry) begin
      m_el = 0; m_sent = 0;
      m_gmin = cfg_green_min; m_gmax = cfg_green_max; m_y = cfg_yellow;
    end else if (p != 0) begin
      own_req    = m_road ? req2 : req1;
      other_pend = m_road ? m_p1 : m_p2;
      if (p == 1 && !m_sent &&
          (m_el >= m_gmax || (m_el >= m_gmin && other_pend && !own_req))) n_dg = 1;
      if (p == 2 && !m_sent && m_el >= m_y) n_dy = 1;
      if (n_dg || n_dy) m_sent = 1;
      if (n_dy) m_road = !m_road;
      if (tick) m_el = (m_el + 1 > SAT) ? SAT : m_el + 1;
    end
    m_ph = p;
    m_dg = n_dg;
    m_dy = n_dy;
    m_p1 = np1;
    m_p2 = np2;
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    chk("done_g", count_done_g, m_dg);
    chk("done_y", count_done_y, m_dy);
    chk("active_road", active_road, m_road);
    chk("elapsed", elapsed, m_el);
    chk("pend1", pend1, m_p1);
    chk("pend2", pend2, m_p2);
    if (count_done_g) begin g_cnt++; g_el = prev_el; end
    if (count_done_y) begin y_cnt++; y_el = prev_el; y_at = cyc; end
    prev_el = elapsed;
    cyc++;
  endtask

  task automatic clear_stats();
    g_cnt = 0; y_cnt = 0; g_el = -1; y_el = -1; y_at = -1; cyc = 0;
  endtask

  task automatic set_cfg(input int gmin, input int gmax, input int y);
    cfg_green_min = gmin[W-1:0];
    cfg_green_max = gmax[W-1:0];
    cfg_yellow    = y[W-1:0];
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; count_g = 1'b0; count_y = 1'b0;
    req1 = 1'b0; req2 = 1'b0;
    set_cfg(0, 0, 0);
    prev_el = 0;
    clear_stats();

    // Reset state and plain max-out at green_max = 10.
    do_reset();
    chk("rst_done_g", count_done_g, 0);
    chk("rst_done_y", count_done_y, 0);
    chk("rst_road", active_road, 0);
    chk("rst_elapsed", elapsed, 0);
    chk("rst_pend", {pend1, pend2}, 0);
    set_cfg(5, 10, 3);
    tick = 1'b1;
    count_g = 1'b1;
    clear_stats();
    repeat (20) step();
    chk("maxout_count", g_cnt, 1);
    chk("maxout_at", g_el, 10);

    // Yellow timeout at 3 toggles the road.
    count_g = 1'b0; count_y = 1'b1;
    clear_stats();
    repeat (8) step();
    chk("yellow_count", y_cnt, 1);
    chk("yellow_at", y_el, 3);
    chk("yellow_road", active_road, 1);

    // Yellow duration 0: pulse on the first cycle after entry.
    count_y = 1'b0;
    repeat (2) step();
    set_cfg(5, 10, 0);
    count_y = 1'b1;
    clear_stats();
    repeat (4) step();
    chk("y0_count", y_cnt, 1);
    chk("y0_cycle", y_at, 1);
    chk("y0_road", active_road, 0);

    // Gap-out: road 2 requests at tick 2, road 1 idle.
    do_reset();
    set_cfg(5, 10, 3);
    count_y = 1'b0; count_g = 1'b1;
    clear_stats();
    repeat (3) step();
    req2 = 1'b1;
    step();
    req2 = 1'b0;
    chk("gap_pend2_set", pend2, 1);
    repeat (10) step();
    chk("gap_count", g_cnt, 1);
    chk("gap_at", g_el, 5);
    count_g = 1'b0; count_y = 1'b1;
    repeat (6) step();
    chk("gap_pend2_held", pend2, 1);
    count_y = 1'b0; count_g = 1'b1;
    step();
    chk("gap_pend2_clr", pend2, 0);
    chk("gap_road", active_road, 1);

    // Own road still demanding: no gap-out, only max-out.
    do_reset();
    set_cfg(5, 10, 3);
    count_g = 1'b1; req1 = 1'b1;
    clear_stats();
    repeat (2) step();
    req2 = 1'b1;
    step();
    req2 = 1'b0;
    repeat (14) step();
    chk("nogap_count", g_cnt, 1);
    chk("nogap_at", g_el, 10);
    req1 = 1'b0;

    // Both enables high is idle: nothing moves.
    count_y = 1'b1;
    step();
    clear_stats();
    repeat (4) step();
    chk("both_pulses", g_cnt + y_cnt, 0);
    chk("both_elapsed", elapsed, 0);

    // Reset mid-green at elapsed 7 drops the pending max-out.
    set_cfg(7, 7, 3);
    count_y = 1'b0;
    repeat (8) step();
    chk("pre_rst_elapsed", elapsed, 7);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_outs", {count_done_g, count_done_y, active_road, pend1, pend2}, 0);
    chk("midrst_elapsed", elapsed, 0);

    // green_min above green_max: max-out wins at 10.
    do_reset();
    set_cfg(12, 10, 3);
    count_g = 1'b1;
    step();
    req2 = 1'b1;
    step();
    req2 = 1'b0;
    clear_stats();
    repeat (14) step();
    chk("minmax_count", g_cnt, 1);
    chk("minmax_at", g_el, 10);

    // Saturation at 255.
    count_g = 1'b0;
    step();
    set_cfg(255, 255, 3);
    count_g = 1'b1;
    clear_stats();
    repeat (262) step();
    chk("sat_elapsed", elapsed, 255);
    chk("sat_count", g_cnt, 1);
    chk("sat_at", g_el, 255);

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        count_g = 1'($urandom_range(0, 1));
        count_y = 1'($urandom_range(0, 1));
      end
      tick = ($urandom_range(0, 3) != 0);
      req1 = ($urandom_range(0, 3) == 0);
      req2 = ($urandom_range(0, 3) == 0);
      set_cfg($urandom_range(0, 12), $urandom_range(0, 12), $urandom_range(0, 6));
      rst = ($urandom_range(0, 99) == 0);
      step();
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
